pipeline_mem_stage: RTL and testbench

Memory-access stage between the EXE→MEM pipeline register and `pipeline_mem2wb`. It drives loads and stores onto a req/ack data-memory bus and aligns byte/half/word lanes. It holds the pipeline with `stall_req` while a transaction is outstanding. It presents the write-back enable, data and destination register to `pipeline_mem2wb`.

---
 rtl/pipeline_mem_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_pipeline_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus, aligns lanes, stalls while busy.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN; addr_error/bus_error are registered one-cycle pulses.
module pipeline_mem_stage #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [ADDR_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic                      wb_in,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_in,
    output logic                      wb_out,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_out,
    output logic                      stall_req,
    output logic                      addr_error,
    output logic                      bus_error,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    input  logic                      dmem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                  dmem_req_reg;
    logic                  dmem_we_reg;
    logic [ADDR_WIDTH-1:0] dmem_addr_reg;
    logic [3:0]            dmem_be_reg;
    logic [DATA_WIDTH-1:0] dmem_wdata_reg;
    logic                  addr_error_reg;
    logic                  bus_error_reg;
    logic                  kill_reg;
    logic [1:0]            size_reg;
    logic [1:0]            off_reg;
    logic                  unsigned_reg;
    logic [DATA_WIDTH-1:0] load_data_reg;

    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] load_data_next;
    logic                  is_mem;
    logic                  size_half;
    logic                  size_word;
    logic                  misaligned;
    logic                  issue;
    logic                  timeout_hit;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [7:0]            rdata_byte [4];

    assign is_mem     = valid_in & (mem_read | mem_write);
    assign size_half  = (mem_size == 2'd1);
    assign size_word  = mem_size[1];
    assign misaligned = (size_half & alu_result[0]) | (size_word & (alu_result[1:0] != 2'b00));
    assign issue      = (state_reg == IDLE) & is_mem & ~misaligned & ~flush;

    // Store lanes are replicated so the memory only needs the byte enables.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        if (mem_size == 2'd0) begin
            be_next    = 4'b0001 << alu_result[1:0];
            wdata_next = {4{store_data[7:0]}};
        end else if (size_half) begin
            be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{store_data[15:0]}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rdata_byte[off_reg];
    assign sel_half = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (size_reg)
            2'd0:    load_data_next = {{(DATA_WIDTH-8){~unsigned_reg & sel_byte[7]}}, sel_byte};
            2'd1:    load_data_next = {{(DATA_WIDTH-16){~unsigned_reg & sel_half[15]}}, sel_half};
            default: load_data_next = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wdog_cnt_reg;

    // An ack in the final watchdog cycle still wins over the timeout.
    assign timeout_hit = (state_reg == BUSY) & ~dmem_ack &
                         (wdog_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_reg <= '0;
        end else if (issue) begin
            wdog_cnt_reg <= '0;
        end else if ((state_reg == BUSY) && !dmem_ack) begin
            wdog_cnt_reg <= wdog_cnt_reg + CNT_W'(1);
        end
    end
`else
    // No watchdog: the timeout condition is constant false, so BUSY waits for ack forever.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_be_reg    <= 4'b0000;
            dmem_wdata_reg <= '0;
            addr_error_reg <= 1'b0;
            bus_error_reg  <= 1'b0;
            kill_reg       <= 1'b0;
            size_reg       <= 2'd0;
            off_reg        <= 2'd0;
            unsigned_reg   <= 1'b0;
            load_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            addr_error_reg <= (state_reg == IDLE) & is_mem & misaligned & ~flush;
            bus_error_reg  <= timeout_hit;
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        dmem_req_reg   <= 1'b1;
                        dmem_we_reg    <= mem_write;
                        dmem_addr_reg  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be_reg    <= be_next;
                        dmem_wdata_reg <= wdata_next;
                        size_reg       <= mem_size;
                        off_reg        <= alu_result[1:0];
                        unsigned_reg   <= mem_unsigned;
                        kill_reg       <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        kill_reg <= 1'b1;
                    end
                    if (dmem_ack) begin
                        dmem_req_reg  <= 1'b0;
                        load_data_reg <= load_data_next;
                    end else if (timeout_hit) begin
                        dmem_req_reg  <= 1'b0;
                        load_data_reg <= '0;
                    end
                end
                RESP: begin
                    kill_reg <= 1'b0;
                end
                default: begin
                    kill_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        wb_out      = 1'b0;
        data_out    = alu_result;
        wb_addr_out = wb_addr_in;
        stall_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_mem) begin
                    stall_req = issue;
                    if (issue) begin
                        state_next = BUSY;
                    end
                end else begin
                    wb_out = valid_in & wb_in & ~flush;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (dmem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (bus_error_reg) begin
                    data_out = '0;
                end else if (!dmem_we_reg) begin
                    data_out = load_data_reg;
                end
                wb_out = wb_in & ~kill_reg & ~flush & ~bus_error_reg;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_be    = dmem_be_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign addr_error = addr_error_reg;
    assign bus_error  = bus_error_reg;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: pass-through, loads, stores, misalignment, flush, reset, watchdog.
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        wb_in;
    logic [4:0]  wb_addr_in;
    logic        wb_out;
    logic [31:0] data_out;
    logic [4:0]  wb_addr_out;
    logic        stall_req;
    logic        addr_error;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int total = 0;
    int bad   = 0;

    pipeline_mem_stage #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .valid_in    (valid_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_unsigned(mem_unsigned),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .wb_in       (wb_in),
        .wb_addr_in  (wb_addr_in),
        .wb_out      (wb_out),
        .data_out    (data_out),
        .wb_addr_out (wb_addr_out),
        .stall_req   (stall_req),
        .addr_error  (addr_error),
        .bus_error   (bus_error),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                          input logic wbi, input logic [4:0] rdst);
        valid_in     = v;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        alu_result   = addr;
        store_data   = sd;
        wb_in        = wbi;
        wb_addr_in   = rdst;
    endtask

    // Load with ack in the last of busy_n BUSY cycles; optional flush during RESP.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] rdata, input int busy_n,
                            input logic [3:0] exp_be, input logic [31:0] exp_data,
                            input logic resp_flush);
        set_op(1'b1, 1'b1, 1'b0, sz, uns, addr, 32'h0, 1'b1, 5'd9);
        #1;
        chk({tag, "_issue_stall"}, {31'd0, stall_req}, 32'd1);
        chk({tag, "_issue_wb"}, {31'd0, wb_out}, 32'd0);
        tick();
        for (int i = 0; i < busy_n; i++) begin
            chk({tag, "_busy_req"}, {31'd0, dmem_req}, 32'd1);
            chk({tag, "_busy_stall"}, {31'd0, stall_req}, 32'd1);
            chk({tag, "_busy_buserr"}, {31'd0, bus_error}, 32'd0);
            if (i == 0) begin
                chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
            end
            if (i == busy_n - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h5A5A_5A5A;
        end
        flush = resp_flush;
        #1;
        chk({tag, "_resp_stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, "_resp_req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_resp_data"}, data_out, exp_data);
        chk({tag, "_resp_wb"}, {31'd0, wb_out}, {31'd0, ~resp_flush});
        chk({tag, "_resp_rd"}, {27'd0, wb_addr_out}, 32'd9);
        $display("txn %s addr=%h data_out=%h wb_out=%b", tag, addr, data_out, wb_out);
        tick();
        flush = 1'b0;
    endtask

    task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                             input logic also_rd, input logic [31:0] sd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        set_op(1'b1, also_rd, 1'b1, sz, 1'b0, addr, sd, 1'b0, 5'd0);
        #1;
        chk({tag, "_issue_stall"}, {31'd0, stall_req}, 32'd1);
        tick();
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
        chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        chk({tag, "_resp_wb"}, {31'd0, wb_out}, 32'd0);
        chk({tag, "_resp_data"}, data_out, addr);
        chk({tag, "_resp_stall"}, {31'd0, stall_req}, 32'd0);
        $display("txn %s addr=%h be=%b wdata=%h", tag, addr, dmem_be, dmem_wdata);
        tick();
    endtask

    task automatic run_misaligned(input string tag, input logic [31:0] addr, input logic [1:0] sz);
        set_op(1'b1, 1'b1, 1'b0, sz, 1'b0, addr, 32'h0, 1'b1, 5'd3);
        #1;
        chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
        chk({tag, "_wb"}, {31'd0, wb_out}, 32'd0);
        tick();
        chk({tag, "_aerr_hi"}, {31'd0, addr_error}, 32'd1);
        chk({tag, "_noreq"}, {31'd0, dmem_req}, 32'd0);
        valid_in = 1'b0;
        tick();
        chk({tag, "_aerr_lo"}, {31'd0, addr_error}, 32'd0);
        $display("txn %s addr=%h size=%0d", tag, addr, sz);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_aerr", {31'd0, addr_error}, 32'd0);
        chk("rst_berr", {31'd0, bus_error}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        $display("txn reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory pass-through, then the same op flushed.
        set_op(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
        #1;
        chk("add_wb", {31'd0, wb_out}, 32'd1);
        chk("add_data", data_out, 32'h0000_1234);
        chk("add_rd", {27'd0, wb_addr_out}, 32'd5);
        chk("add_stall", {31'd0, stall_req}, 32'd0);
        flush = 1'b1;
        #1;
        chk("add_flush_wb", {31'd0, wb_out}, 32'd0);
        flush = 1'b0;
        $display("txn add data_out=%h", data_out);
        tick();

        run_load("lb",  32'h0000_1003, 2'd0, 1'b0, 32'h80FF_FFFF, 3, 4'b1000, 32'hFFFF_FF80, 1'b0);
        run_load("lbu", 32'h0000_1003, 2'd0, 1'b1, 32'h80FF_FFFF, 3, 4'b1000, 32'h0000_0080, 1'b0);
        run_load("lh",  32'h0000_1002, 2'd1, 1'b0, 32'h8001_7777, 1, 4'b1100, 32'hFFFF_8001, 1'b0);
        run_load("lhu", 32'h0000_1000, 2'd1, 1'b1, 32'h1234_F00D, 2, 4'b0011, 32'h0000_F00D, 1'b0);
        run_load("lw",  32'h0000_1004, 2'd2, 1'b0, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        run_load("lb1", 32'h0000_1001, 2'd0, 1'b0, 32'h1122_7F44, 1, 4'b0010, 32'h0000_007F, 1'b0);
        run_load("lw_rflush", 32'h0000_1008, 2'd3, 1'b0, 32'hCAFE_0001, 1, 4'b1111, 32'hCAFE_0001, 1'b1);

        run_store("sh", 32'h0000_2002, 2'd1, 1'b0, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
        run_store("sb_rw", 32'h0000_3001, 2'd0, 1'b1, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
        run_store("sw", 32'h0000_3008, 2'd2, 1'b0, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

        run_misaligned("mis_lw", 32'h0000_3001, 2'd2);
        run_misaligned("mis_lh", 32'h0000_3003, 2'd1);
        run_misaligned("mis_rsv", 32'h0000_3002, 2'd3);

        // Flush while BUSY: bus transfer completes but write-back is suppressed.
        set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 5'd11);
        tick();
        flush = 1'b1;
        #1;
        chk("fl_busy_stall", {31'd0, stall_req}, 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_req_held", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("fl_req_held2", {31'd0, dmem_req}, 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("fl_resp_wb", {31'd0, wb_out}, 32'd0);
        chk("fl_resp_stall", {31'd0, stall_req}, 32'd0);
        chk("fl_resp_req", {31'd0, dmem_req}, 32'd0);
        $display("txn flush_busy wb_out=%b", wb_out);
        tick();
        set_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_00AB, 32'h0, 1'b1, 5'd6);
        #1;
        chk("fl_next_add_wb", {31'd0, wb_out}, 32'd1);
        tick();
        run_load("fl_next_lw", 32'h0000_4004, 2'd2, 1'b0, 32'h2468_ACE0, 2, 4'b1111, 32'h2468_ACE0, 1'b0);

        // Asynchronous reset in the middle of a transaction.
        set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 1'b1, 5'd12);
        tick();
        chk("rstm_req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rstm_req", {31'd0, dmem_req}, 32'd0);
        chk("rstm_stall", {31'd0, stall_req}, 32'd0);
        chk("rstm_be", {28'd0, dmem_be}, 32'd0);
        $display("txn reset_mid_busy");
        @(negedge clk);
        rst_n = 1'b1;
        run_load("rstm_lw", 32'h0000_6008, 2'd2, 1'b0, 32'h0F0F_0F0F, 1, 4'b1111, 32'h0F0F_0F0F, 1'b0);

`ifdef MEM_TIMEOUT_EN
        set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 1'b1, 5'd13);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("wd_busy_req", {31'd0, dmem_req}, 32'd1);
            chk("wd_busy_berr", {31'd0, bus_error}, 32'd0);
            tick();
        end
        valid_in = 1'b0;
        #1;
        chk("wd_berr", {31'd0, bus_error}, 32'd1);
        chk("wd_req", {31'd0, dmem_req}, 32'd0);
        chk("wd_wb", {31'd0, wb_out}, 32'd0);
        chk("wd_data", data_out, 32'd0);
        chk("wd_stall", {31'd0, stall_req}, 32'd0);
        tick();
        chk("wd_berr_lo", {31'd0, bus_error}, 32'd0);
        $display("txn watchdog_timeout");
`else
        run_load("slow_lw", 32'h0000_5000, 2'd2, 1'b0, 32'h7777_1111, 8, 4'b1111, 32'h7777_1111, 1'b0);
        chk("slow_berr", {31'd0, bus_error}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
